// File: rtl/cellram_responder.sv
// cellram_responder: burst-mode cell RAM model with pipelined reads and refresh stalls
module cellram_responder #(
  parameter int DEPTH_LOG2       = 12,
  parameter int READ_LATENCY     = 3,
  parameter int REFRESH_INTERVAL = 256,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] mem_addr,
  input  logic        mem_addr_valid,
  input  logic        mem_we,
  input  logic        mem_oe,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_rdata_valid,
  output logic        mem_wait,
  output logic        protocol_error
);
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int CW = $clog2(REFRESH_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_BURST, REFRESH} state_t;
  logic [15:0] mem [2**DEPTH_LOG2];
  state_t state, saved;
  logic [DEPTH_LOG2-1:0] ptr, addr;
  logic [TW-1:0] timer;
  logic [CW-1:0] rcnt;
  logic pending, accept, wr, rd, wrap;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [15:0] rd_q;
  logic [15:0] pipe_d [1:READ_LATENCY-1];
  logic unused_addr;
  assign unused_addr = ^mem_addr[22:DEPTH_LOG2];
  assign accept = !mem_wait;
  assign wr = accept && (mem_addr_valid ? mem_we : state == WRITE_BURST && mem_we);
  assign rd = accept && !wr && (mem_addr_valid ? mem_oe : state == READ_BURST && mem_oe);
  assign addr = mem_addr_valid ? mem_addr[DEPTH_LOG2-1:0] : ptr;
  assign wrap = timer == TW'(REFRESH_INTERVAL - 1);
  assign mem_rdata = pipe_d[READ_LATENCY-1];
  assign mem_rdata_valid = pipe_v[READ_LATENCY-1];
  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= mem_wdata;
    rd_q <= mem[addr];
  end
  // Refresh waits only for reads not yet on the bus; the word leaving this cycle needs no slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      saved <= IDLE;
      ptr <= '0;
      timer <= '0;
      rcnt <= '0;
      pending <= 1'b0;
      mem_wait <= 1'b0;
      protocol_error <= 1'b0;
      pipe_v <= '0;
      for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      timer <= wrap ? '0 : timer + 1'b1;
      pipe_v <= {pipe_v[READ_LATENCY-2:0], rd};
      pipe_d[1] <= rd_q;
      for (int i = 2; i < READ_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
      if (wrap) begin
        pending <= 1'b1;
        mem_wait <= 1'b1;
      end
      if (state == REFRESH) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == CW'(REFRESH_CYCLES - 1)) begin
          state <= saved;
          pending <= 1'b0;
          mem_wait <= 1'b0;
        end
      end else if (pending && pipe_v[READ_LATENCY-2:0] == '0) begin
        state <= REFRESH;
        saved <= state;
        rcnt <= '0;
      end else if (accept) begin
        if (wr || rd) ptr <= addr + 1'b1;
        if (mem_addr_valid) state <= mem_we ? WRITE_BURST : mem_oe ? READ_BURST : IDLE;
        else if (!(wr || rd)) state <= IDLE;
        if (mem_we && mem_oe) protocol_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cellram_responder.sv
// tb_cellram_responder: vector-table checks of bursts, wrap, refresh stall and reset
module tb_cellram_responder;
  logic clk = 0, reset = 1, reset_r = 1;
  always #5 clk = ~clk;
  logic [22:0] addr = 0, addr_r = 0;
  logic av = 0, we = 0, oe = 0, av_r = 0, we_r = 0, oe_r = 0;
  logic [15:0] wd = 0, wd_r = 0, rdata, rdata_r;
  logic rv, rv_r, wt, wt_r, pe, pe_r;
  typedef struct {
    bit av, we, oe;
    logic [22:0] a;
    logic [15:0] d;
    bit ev;
    logic [15:0] ed;
    bit ew, ep;
  } vec_t;
  vec_t tv[$], tr[$];
  int n_vec = 0, n_bad = 0;

  cellram_responder #(.REFRESH_INTERVAL(4096)) dut (
    .clk(clk), .reset(reset), .mem_addr(addr), .mem_addr_valid(av), .mem_we(we), .mem_oe(oe),
    .mem_wdata(wd), .mem_rdata(rdata), .mem_rdata_valid(rv), .mem_wait(wt), .protocol_error(pe));
  cellram_responder #(.REFRESH_INTERVAL(16), .REFRESH_CYCLES(4)) dut_r (
    .clk(clk), .reset(reset_r), .mem_addr(addr_r), .mem_addr_valid(av_r), .mem_we(we_r), .mem_oe(oe_r),
    .mem_wdata(wd_r), .mem_rdata(rdata_r), .mem_rdata_valid(rv_r), .mem_wait(wt_r), .protocol_error(pe_r));

  function automatic vec_t mk(bit v, w, o, logic [22:0] a, logic [15:0] d, bit ev, logic [15:0] ed, bit ew, bit ep);
    vec_t t;
    t = '{v, w, o, a, d, ev, ed, ew, ep};
    return t;
  endfunction

  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic drv(bit v, w, o, logic [22:0] a, logic [15:0] d);
    av = v; we = w; oe = o; addr = a; wd = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v, bit r, int i);
    logic ov, ow, op;
    logic [15:0] od;
    tick();
    if (r) begin
      reset_r = 0; av_r = v.av; we_r = v.we; oe_r = v.oe; addr_r = v.a; wd_r = v.d;
    end else drv(v.av, v.we, v.oe, v.a, v.d);
    @(negedge clk);
    ov = r ? rv_r : rv;
    ow = r ? wt_r : wt;
    op = r ? pe_r : pe;
    od = r ? rdata_r : rdata;
    chk($sformatf("%s%0d valid", r ? "ref" : "vec", i), 16'(ov), 16'(v.ev));
    if (v.ev) chk($sformatf("%s%0d rdata", r ? "ref" : "vec", i), od, v.ed);
    chk($sformatf("%s%0d wait", r ? "ref" : "vec", i), 16'(ow), 16'(v.ew));
    chk($sformatf("%s%0d perr", r ? "ref" : "vec", i), 16'(op), 16'(v.ep));
  endtask

  initial begin
    // write burst 0x10, then read it back
    tv.push_back(mk(1,1,0,'h10,'h1111, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,'h2222, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,'h3333, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,'h4444, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,'h10,0, 0,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 1,'h1111,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'h2222,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'h3333,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'h4444,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    // pointer wrap at top of array, upper address bits ignored
    tv.push_back(mk(1,1,0,'hFFF,'hAAAA, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,'hBBBB, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,'h7FF000,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,'hFFF,0, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'hBBBB,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'hAAAA,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    // new burst aborts a running write burst
    tv.push_back(mk(1,1,0,'h32,'hDEAD, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,0,'h30,'h0101, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,'h0202, 0,0,0,0));
    tv.push_back(mk(1,1,0,'h40,'h0303, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,'h0404, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,'h30,0, 0,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,'h40,0, 1,'h0101,0,0));
    tv.push_back(mk(0,0,1,0,0, 1,'h0202,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'hDEAD,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'h0303,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,'h0404,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0));
    // write and read together: write wins, error is sticky
    tv.push_back(mk(1,1,1,'h20,'h5A5A, 0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,1));
    tv.push_back(mk(1,0,1,'h20,0, 0,0,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,1));
    tv.push_back(mk(0,0,0,0,0, 1,'h5A5A,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,1));
    // refresh: timer wraps in cycle 15, stall 16..22, burst resumes at 0x104
    for (int i = 0; i <= 28; i++)
      tr.push_back(mk(i == 0 || i == 12, i < 12, i >= 12 && i <= 24, (i == 0 || i == 12) ? 23'h100 : 23'h0,
                      i < 12 ? 16'hC000 + 16'(i) : 16'h0,
                      (i >= 15 && i <= 18) || i == 26 || i == 27,
                      i <= 18 ? 16'hC000 + 16'(i - 15) : 16'hC004 + 16'(i - 26),
                      i >= 16 && i <= 22, 0));

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset valid", 16'(rv), 16'h0);
    chk("reset rdata", rdata, 16'h0);
    chk("reset wait", 16'(wt), 16'h0);
    chk("reset perr", 16'(pe), 16'h0);
    foreach (tv[i]) apply(tv[i], 0, i);

    // reset with two reads in flight
    tick(); drv(1,1,0,'h50,'h7777);
    tick(); drv(0,0,0,0,0);
    tick(); drv(1,0,1,'h50,0);
    tick(); drv(0,0,1,0,0);
    tick(); drv(0,0,0,0,0); reset = 1;
    tick(); reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst%0d valid", k), 16'(rv), 16'h0);
      chk($sformatf("rst%0d wait", k), 16'(wt), 16'h0);
      chk($sformatf("rst%0d perr", k), 16'(pe), 16'h0);
      if (k == 0) chk("rst rdata", rdata, 16'h0);
      tick();
    end
    drv(1,0,1,'h50,0);
    tick(); drv(0,0,0,0,0);
    tick();
    tick();
    @(negedge clk);
    chk("post-reset valid", 16'(rv), 16'h1);
    chk("post-reset rdata", rdata, 16'h7777);

    foreach (tr[i]) apply(tr[i], 1, i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cellram_responder.md
# cellram_responder

Synchronous burst-mode cell RAM responder that serves the memory bus driven by the arbitration logic: mem_addr/mem_addr_valid/mem_we/mem_oe requests, 16-bit write data and pipelined read data. It holds a parameterised on-chip word array, supports address-latched bursts with automatic increment, returns reads after a fixed latency, and periodically stalls the initiator with mem_wait for refresh. It replaces the bare bram behind the arbitrator in cosim and models real CellRAM stall behaviour.

## Interface
- DEPTH_LOG2, 12, number of address bits decoded (array = 2^DEPTH_LOG2 x 16 bits); upper mem_addr bits ignored
- READ_LATENCY, 3, issue-to-data cycles, legal 2..6
- REFRESH_INTERVAL, 256, cycles between refresh requests
- REFRESH_CYCLES, 4, cycles spent in refresh
- clk  in  1  single clock; everything is synchronous to it
- reset  in  1  synchronous, active-high reset
- mem_addr  in  23  burst start address, sampled when mem_addr_valid=1
- mem_addr_valid  in  1  starts a new burst
- mem_we  in  1  write command / write burst continue
- mem_oe  in  1  read command / read burst continue
- mem_wdata  in  16  write data (inout mem_data is split at top level)
- mem_rdata  out  16  read data
- mem_rdata_valid  out  1  mem_rdata holds a returned word this cycle
- mem_wait  out  1  registered stall; beats presented while high are ignored
- protocol_error  out  1  sticky: mem_we and mem_oe high on the same accepted cycle

## Operation
- States: IDLE, WRITE_BURST, READ_BURST, REFRESH. Burst pointer ptr is DEPTH_LOG2 bits.
- Accepted cycle: any cycle with mem_wait=0.
- Accepted mem_addr_valid=1 (any state except REFRESH): ptr <= mem_addr[DEPTH_LOG2-1:0]+1; if mem_we, write mem_wdata to mem_addr, go WRITE_BURST; else if mem_oe, issue read of mem_addr, go READ_BURST; else go IDLE. Aborts any running burst in the same cycle.
- mem_we and mem_oe both high on accept: write wins, protocol_error <= 1 (cleared only by reset).
- WRITE_BURST, accepted, addr_valid=0, mem_we=1: write mem_wdata to ptr, ptr++. mem_we=0: go IDLE.
- READ_BURST, accepted, addr_valid=0, mem_oe=1: issue read of ptr, ptr++. mem_oe=0: go IDLE; in-flight reads still complete.
- ptr wraps 2^DEPTH_LOG2-1 -> 0.
- Refresh: free-running timer 0..REFRESH_INTERVAL-1; on wrap set pending. pending -> mem_wait=1 from next cycle. Enter REFRESH when pending and read pipeline empty; stay REFRESH_CYCLES cycles; then clear pending, drop mem_wait, return to saved state with ptr unchanged (paused burst resumes).
- Pending while a second wrap occurs: single refresh, no queueing.

## Timing
- Reset: mem_rdata=0, mem_rdata_valid=0, mem_wait=0, protocol_error=0, state IDLE, ptr=0, timer=0, pending=0, read pipeline flushed. Array contents are not cleared.
- Read issued at cycle T: mem_rdata_valid=1 with data at T+READ_LATENCY, one word per issued beat, back-to-back at full rate.
- Write accepted at T is visible to a read issued at T+1 or later.
- mem_wait rises the cycle after timer wrap; stays high through drain plus REFRESH_CYCLES; falls the cycle after the last refresh cycle.
- Reset mid-burst: in-flight reads dropped (no valid after reset), state IDLE next cycle.

## Test plan
- Write burst addr 0x000010, data 0x1111,0x2222,0x3333,0x4444; then read burst 4 beats from 0x000010 -> same words on mem_rdata, first at issue+3, 4 consecutive valid cycles.
- Write burst start 0xFFF (DEPTH_LOG2=12), 2 beats 0xAAAA,0xBBBB -> read of 0x000 returns 0xBBBB, 0xFFF returns 0xAAAA.
- REFRESH_INTERVAL=16, REFRESH_CYCLES=4, continuous read burst -> mem_wait high from cycle 17, valid pipeline drains (3 words), wait low 4 cycles later, burst resumes at next address with no skipped or repeated words.
- Accept with mem_we=mem_oe=1, data 0x5A5A at 0x20 -> 0x20 reads 0x5A5A, protocol_error=1 until reset.
- Reset asserted mid read burst with 2 reads in flight -> mem_rdata_valid=0 after reset, mem_wait=0; subsequent read of previously written address still returns old data.
- New mem_addr_valid during write burst at 0x40 -> next write lands at 0x40, prior burst pointer abandoned.
